// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port round-robin writeback arbiter with register file zero-init
module regfile_wb_arbiter #(
  parameter int mem_width = 32,
  parameter int mem_depth = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         req0_valid,
  input  logic [$clog2(mem_depth)-1:0] req0_addr,
  input  logic [mem_width-1:0]         req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [$clog2(mem_depth)-1:0] req1_addr,
  input  logic [mem_width-1:0]         req1_data,
  output logic                         req1_ready,
  output logic                         we,
  output logic [$clog2(mem_depth)-1:0] D_addr,
  output logic [mem_width-1:0]         Rin,
  output logic                         init_done
);

  localparam int AW = $clog2(mem_depth);
  localparam logic [AW-1:0] LAST_ADDR = AW'(mem_depth - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  last1_q, last1_d;   // 1: req1 was granted most recently
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [mem_width-1:0]  rin_q, rin_d;
  logic [AW-1:0]         issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      last1_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      rin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last1_q <= last1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      rin_q   <= rin_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last1_d    = last1_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    rin_d      = rin_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    issue      = clear ? '0 : cnt_q;

    case (state_q)
      INIT: begin
        we_d   = 1'b1;
        addr_d = issue;
        rin_d  = '0;
        if (issue == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = issue + AW'(1);
        end
      end
      RUN: begin
        if (clear) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          // On contention the requester that did not win last time goes first
          req0_ready = req0_valid && (!req1_valid || last1_q);
          req1_ready = req1_valid && (!req0_valid || !last1_q);
          if (req0_ready) begin
            we_d    = |req0_addr;
            addr_d  = req0_addr;
            rin_d   = req0_data;
            last1_d = 1'b0;
          end else if (req1_ready) begin
            we_d    = |req1_addr;
            addr_d  = req1_addr;
            rin_d   = req1_data;
            last1_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign we        = we_q;
  assign D_addr    = addr_q;
  assign Rin       = rin_q;
  assign init_done = (state_q == RUN);

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter mem_width, default 32, data width of the register file write port.
REQ-002 SHALL have parameter mem_depth, default 32, number of registers; the address width SHALL be $clog2(mem_depth).
REQ-003 SHALL have port clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous request to re-run zero-initialisation.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1 each  writeback request valid.
REQ-007 SHALL have ports req0_addr / req1_addr  input  $clog2(mem_depth) each  destination register.
REQ-008 SHALL have ports req0_data / req1_data  input  mem_width each  writeback data.
REQ-009 SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle.
REQ-010 SHALL have port we  output  1  register file write enable, registered.
REQ-011 SHALL have port D_addr  output  $clog2(mem_depth)  register file write address, registered.
REQ-012 SHALL have port Rin  output  mem_width  register file write data, registered.
REQ-013 SHALL have port init_done  output  1  high while in RUN state.

Function
REQ-014 SHALL implement FSM states INIT and RUN; reset SHALL enter INIT with init counter = 0.
REQ-015 In INIT, each rising edge SHALL register we=1, D_addr=counter, Rin=0 and increment the counter.
REQ-016 The edge that issues address mem_depth-1 SHALL also move the FSM to RUN and set init_done=1; the counter SHALL return to 0.
REQ-017 In INIT, req0_ready and req1_ready SHALL both be 0.
REQ-018 In RUN, ready SHALL be combinational: at most one of req0_ready/req1_ready high, and only for a requester whose valid is high.
REQ-019 Arbitration SHALL be round-robin: if only one requester is valid it is granted; if both are valid, the requester not granted last is granted.
REQ-020 The last-grant pointer SHALL update only on a transfer (valid && ready); its reset value SHALL give req0 priority at the first contention.
REQ-021 A transfer SHALL produce, on the same edge, we=1, D_addr=granted addr, Rin=granted data (one-cycle latency to the write port).
REQ-022 A transfer with addr = 0 SHALL be accepted (ready high) but SHALL register we=0 (x0 is hard-wired zero).
REQ-023 In RUN with no transfer, the edge SHALL register we=0; D_addr and Rin SHALL hold their previous values.
REQ-024 A requester not granted SHALL see ready=0 and SHALL be served on a later cycle; no request data is buffered internally.
REQ-025 Both requesters targeting the same address SHALL be serialised in grant order; the later write SHALL win in the register file.
REQ-026 clear=1 in RUN SHALL take priority over requests: ready=0 that cycle, FSM to INIT, init_done=0, counter=0, we=0 on that edge.
REQ-027 clear=1 during INIT SHALL restart the counter at 0 on that edge (we=1, D_addr=0).
REQ-028 init_done, we, D_addr, Rin and ready SHALL never be X after reset assertion.

Reset
REQ-029 On reset low, regardless of clk: we=0, D_addr=0, Rin=0, init_done=0, FSM=INIT, counter=0, pointer=req1-last; ready outputs 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL abort immediately; after release, initialisation SHALL restart from address 0.

Verification
REQ-031 Release reset, no requests -> edges 1..32 show we=1, D_addr=0..31, Rin=0; init_done=1 after edge 32; we=0 from edge 33.
REQ-032 RUN, req0 only, addr=5, data=0xA5A5A5A5 -> req0_ready=1 same cycle; next edge we=1, D_addr=5, Rin=0xA5A5A5A5.
REQ-033 RUN, both valid continuously (req0 addr=3 data=1, req1 addr=4 data=2) -> grants alternate req0, req1, req0...; write port alternates addr 3/4.
REQ-034 RUN, req1 valid, addr=0, data=0xFFFFFFFF -> req1_ready=1; next edge we=0.
REQ-035 RUN, clear=1 with req0 valid -> req0_ready=0, we=0, init_done=0 on that edge; then 32 zero-writes addr 0..31 before req0 is accepted.
REQ-036 Reset low during INIT after address 10 -> outputs return to reset values immediately; after release writes restart at D_addr=0.
